// File: rtl/riscv_pkg.sv
// Shared types for the fetch slice: next-PC select and fetch FSM states.
// PC_MISALIGN_TRAP_EN adds the TRAP state used by misaligned redirects.
package riscv_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_TARGET = 2'b01,
        PC_ALU    = 2'b10
    } pcsrc_e;

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        FETCH      = 2'b01,
        REDIR_PEND = 2'b10,
        TRAP       = 2'b11
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        FETCH      = 2'b01,
        REDIR_PEND = 2'b10
    } fetch_state_e;
`endif

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_next_mux.sv
// Redirect detection, target select and target alignment.
// PC_MISALIGN_TRAP_EN keeps raw low bits and flags misalignment.
module pc_next_mux
    import riscv_pkg::*;
(
    input  logic [1:0]  pc_src,
    input  logic [31:0] pc_target,
    input  logic [31:0] alu_result,
    output logic        redirect,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] raw;

    // select the redirect target; 2'b11 behaves like PC+4
    always_comb begin
        redirect   = 1'b0;
        raw        = 32'd0;
        target     = 32'd0;
        misaligned = 1'b0;
        case (pc_src)
            PC_TARGET: begin
                redirect = 1'b1;
                raw      = pc_target;
            end
            PC_ALU: begin
                redirect = 1'b1;
                raw      = {alu_result[31:1], 1'b0};
            end
            default: begin
                redirect = 1'b0;
                raw      = 32'd0;
            end
        endcase
`ifdef PC_MISALIGN_TRAP_EN
        target     = raw;
        misaligned = redirect && (raw[1:0] != 2'b00);
`else
        target     = {raw[31:2], 2'b00};
        misaligned = 1'b0;
`endif
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register, imem request handshake and redirect handling.
// PC_MISALIGN_TRAP_EN enables the sticky misaligned-target trap.
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    input  logic        StallF,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        FlushD,
    output logic        FlushE,
    output logic        TrapF,
    output logic [31:0] TrapPC
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    logic         held_q, held_d;
    logic         redirect;
    logic         misaligned;
    logic [31:0]  target;
`ifdef PC_MISALIGN_TRAP_EN
    logic         trap_q, trap_d;
    logic [31:0]  trap_pc_q, trap_pc_d;
`endif

    pc_next_mux u_mux (
        .pc_src     (PCSrcE),
        .pc_target  (PCTargetE),
        .alu_result (ALUResultE),
        .redirect   (redirect),
        .target     (target),
        .misaligned (misaligned)
    );

    // next-state, next-PC and handshake outputs
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        held_d   = held_q;
        imem_req = 1'b0;
        FlushD   = redirect;
        FlushE   = redirect;
`ifdef PC_MISALIGN_TRAP_EN
        trap_d    = trap_q;
        trap_pc_d = trap_pc_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = !StallF || held_q;
                held_d   = imem_req && !imem_ready;
                if (redirect && misaligned) begin
`ifdef PC_MISALIGN_TRAP_EN
                    state_d   = TRAP;
                    trap_d    = 1'b1;
                    trap_pc_d = target;
                    held_d    = 1'b0;
`endif
                end else if (redirect) begin
                    if (!imem_req || imem_ready) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = REDIR_PEND;
                    end
                end else if (imem_req && imem_ready) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            REDIR_PEND: begin
                imem_req = 1'b1;
                held_d   = !imem_ready;
                if (redirect && misaligned) begin
`ifdef PC_MISALIGN_TRAP_EN
                    state_d   = TRAP;
                    trap_d    = 1'b1;
                    trap_pc_d = target;
                    held_d    = 1'b0;
`endif
                end else begin
                    if (redirect) begin
                        pend_d = target;
                    end
                    if (imem_ready) begin
                        pc_d    = redirect ? target : pend_q;
                        state_d = FETCH;
                        FlushD  = 1'b1;
                    end
                end
            end
`ifdef PC_MISALIGN_TRAP_EN
            TRAP: begin
                state_d = TRAP;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and PC registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            held_q  <= held_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // sticky trap flag and offending target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q    <= 1'b0;
            trap_pc_q <= 32'd0;
        end else begin
            trap_q    <= trap_d;
            trap_pc_q <= trap_pc_d;
        end
    end

    assign TrapF  = trap_q;
    assign TrapPC = trap_pc_q;
`else
    assign TrapF  = 1'b0;
    assign TrapPC = 32'd0;
`endif

    assign PCF       = pc_q;
    assign imem_addr = pc_q;
    assign PCPlus4F  = pc_q + PC_STEP;

endmodule
